// File: rtl/jtpang_pkg.sv
// Shared types for the Pang object DMA: transfer FSM states and object record size.
package jtpang_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        FLUSH,
        DONE
    } state_t;

    localparam int OBJ_BYTES = 4;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with one clock of latency.
module jtframe_dual_ram #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    input  logic          we0,
    input  logic [AW-1:0] addr1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem [0:2**AW-1];

    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= data0;
        q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtpang_objdma.sv
// Object DMA master: copies LEN bytes of object VRAM into a local buffer while holding the Z80 bus.
// Renderer reads have 1 clk latency; JTPANG_OBJDMA_DBUF_EN selects a double-buffered object RAM.
module jtpang_objdma
    import jtpang_pkg::*;
#(
    parameter int AW  = 9,
    parameter int LEN = 512
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          dma_cs,
    input  logic          wr_n,
    output logic          busrq_n,
    input  logic          busak_n,
    output logic [AW-1:0] dma_addr,
    input  logic [7:0]    vram_dout,
    input  logic          lvbl,
    input  logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_dout,
    output logic          busy
);

    localparam logic [AW-1:0] LAST = AW'(LEN - 1);

    state_t        st;
    logic          trig, trig_l, trig_rise;
    logic          pend;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          ram_we;

    assign trig      = dma_cs & ~wr_n;
    assign trig_rise = trig & ~trig_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            busrq_n  <= 1'b1;
            busy     <= 1'b0;
            dma_addr <= '0;
            pend     <= 1'b0;
            trig_l   <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
        end else begin
            trig_l <= trig;
            wr_en  <= 1'b0;
            if (trig_rise && st != IDLE) pend <= 1'b1;
            case (st)
                IDLE: begin
                    if (trig_rise || pend) begin
                        st      <= REQ;
                        busrq_n <= 1'b0;
                        busy    <= 1'b1;
                        pend    <= 1'b0;
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        dma_addr <= '0;
                        st       <= XFER;
                    end
                end
                XFER: begin
                    if (busak_n) begin
                        // CPU took the bus back: keep what was copied so far
                        st      <= IDLE;
                        busrq_n <= 1'b1;
                        busy    <= 1'b0;
                    end else if (cen) begin
                        wr_en   <= 1'b1;
                        wr_addr <= dma_addr;
                        if (dma_addr == LAST) st <= FLUSH;
                        else dma_addr <= dma_addr + 1'b1;
                    end
                end
                FLUSH: begin
                    st      <= DONE;
                    busrq_n <= 1'b1;
                end
                DONE: begin
                    if (busak_n) begin
                        if (pend || trig_rise) begin
                            st      <= REQ;
                            busrq_n <= 1'b0;
                            pend    <= 1'b0;
                        end else begin
                            st   <= IDLE;
                            busy <= 1'b0;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // The byte in flight when the bus is reclaimed is not trusted
    assign ram_we = wr_en & ~busak_n;

`ifdef JTPANG_OBJDMA_DBUF_EN
    localparam int RAW = AW + 1;

    logic           bank, lvbl_l, done_flag;
    logic [RAW-1:0] ram_waddr, ram_raddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank      <= 1'b0;
            lvbl_l    <= 1'b1;
            done_flag <= 1'b0;
        end else begin
            lvbl_l <= lvbl;
            // Swap is held off while the last byte is still being written
            if (lvbl_l && !lvbl && done_flag && st != FLUSH) begin
                bank      <= ~bank;
                done_flag <= 1'b0;
            end
            if (st == FLUSH) done_flag <= 1'b1;
        end
    end

    assign ram_waddr = {~bank, wr_addr};
    assign ram_raddr = {bank, obj_addr};
`else
    localparam int RAW = AW;

    logic [RAW-1:0] ram_waddr, ram_raddr;
    logic           unused_lvbl;

    assign ram_waddr   = wr_addr;
    assign ram_raddr   = obj_addr;
    assign unused_lvbl = lvbl;
`endif

    jtframe_dual_ram #(
        .DW (8),
        .AW (RAW)
    ) u_buf (
        .clk   (clk),
        .addr0 (ram_waddr),
        .data0 (vram_dout),
        .we0   (ram_we),
        .addr1 (ram_raddr),
        .q1    (obj_dout)
    );

endmodule

// File: tb/tb_jtpang_objdma.sv
// Self-checking bench for jtpang_objdma with a VRAM model, a Z80 bus-grant model and a buffer reference.
module tb_jtpang_objdma;

    localparam int AW  = 9;
    localparam int LEN = 512;
    localparam int N   = 2**AW;

    logic          rst = 1'b1;
    logic          clk = 1'b0;
    logic          cen = 1'b0;
    logic          dma_cs = 1'b0;
    logic          wr_n = 1'b1;
    logic          busrq_n, busak_n, busy;
    logic [AW-1:0] dma_addr;
    logic [7:0]    vram_dout;
    logic          lvbl = 1'b1;
    logic [AW-1:0] obj_addr = '0;
    logic [7:0]    obj_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] vram    [N];
    logic [7:0] exp_buf [N];

    int   cen_div = 1;
    int   cen_cnt = 0;
    logic ack_q = 1'b1;
    logic force_rel = 1'b0;
    int   rq_cnt = 0;

    // monitor state
    int            m_low, m_steps, m_bad, m_rq_falls, m_max;
    logic [AW-1:0] m_prev;
    logic          m_prev_cen, m_prev_rq;

    jtpang_objdma #(.AW(AW), .LEN(LEN)) dut (
        .rst       (rst),
        .clk       (clk),
        .cen       (cen),
        .dma_cs    (dma_cs),
        .wr_n      (wr_n),
        .busrq_n   (busrq_n),
        .busak_n   (busak_n),
        .dma_addr  (dma_addr),
        .vram_dout (vram_dout),
        .lvbl      (lvbl),
        .obj_addr  (obj_addr),
        .obj_dout  (obj_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Registered VRAM read port
    always @(posedge clk) vram_dout <= vram[dma_addr];

    // CPU grants the bus 3 clk after a request, releases 1 clk after it is dropped
    always @(posedge clk) begin
        if (!busrq_n) begin
            if (rq_cnt >= 2) ack_q <= 1'b0;
            else rq_cnt <= rq_cnt + 1;
        end else begin
            rq_cnt <= 0;
            ack_q  <= 1'b1;
        end
    end
    assign busak_n = ack_q | force_rel;

    always @(posedge clk) begin
        #1;
        cen_cnt = (cen_cnt + 1 >= cen_div) ? 0 : cen_cnt + 1;
        cen     = (cen_cnt == 0);
    end

    task automatic mon_reset();
        m_low = 0; m_steps = 0; m_bad = 0; m_rq_falls = 0; m_max = 0;
        m_prev = '0; m_prev_cen = 1'b0; m_prev_rq = busrq_n;
    endtask

    task automatic mon_cycle();
        @(negedge clk);
        if (!busrq_n && m_prev_rq) m_rq_falls++;
        m_prev_rq = busrq_n;
        if (!busak_n) begin
            m_low++;
            if (m_low >= 3 && dma_addr != m_prev) begin
                m_steps++;
                if (int'(dma_addr) != int'(m_prev) + 1 || !m_prev_cen) m_bad++;
            end
            if (m_low >= 2 && int'(dma_addr) > m_max) m_max = int'(dma_addr);
            m_prev = dma_addr;
        end else begin
            m_low = 0;
        end
        m_prev_cen = cen;
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        dma_cs = 1'b1; wr_n = 1'b0;
        @(negedge clk);
        dma_cs = 1'b0; wr_n = 1'b1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) vram[i] = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit timeout);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        timeout = busy;
    endtask

    task automatic scan(output int bad, output int first);
        bad = 0; first = -1;
        for (int a = 0; a <= N; a++) begin
            @(negedge clk);
            if (a > 0 && obj_dout !== exp_buf[a-1]) begin
                bad++;
                if (first < 0) first = a - 1;
            end
            if (a < N) obj_addr = AW'(a);
        end
    endtask

    task automatic read_obj(input int addr, output logic [7:0] d);
        @(negedge clk);
        obj_addr = AW'(addr);
        @(negedge clk);
        d = obj_dout;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busrq_n !== 1'b1) begin errors++; $display("FAIL reset_busrq_n: got %b want 1", busrq_n); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (dma_addr !== '0) begin errors++; $display("FAIL reset_dma_addr: got %h want 000", dma_addr); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int n = 0, bad, first;
        logic [7:0] d;
        for (int i = 0; i < N; i++) vram[i] = 8'(i) ^ 8'h5A;
        cen_div = 1;
        mon_reset();
        pulse_trig();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        while (busy && n < 3000) begin mon_cycle(); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_timeout: busy %b after %0d clk, want 0", busy, n); end
        checks++;
        if (busrq_n !== 1'b1) begin errors++; $display("FAIL basic_busrq_n: got %b want 1", busrq_n); end
        checks++;
        if (m_max != LEN - 1) begin errors++; $display("FAIL basic_max_addr: got %0d want %0d", m_max, LEN - 1); end
        checks++;
        if (m_steps != LEN - 1 || m_bad != 0) begin
            errors++; $display("FAIL basic_steps: got %0d steps %0d bad, want %0d steps 0 bad", m_steps, m_bad, LEN - 1);
        end
        for (int i = 0; i < LEN; i++) exp_buf[i] = vram[i];
        scan(bad, first);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_buffer: %0d bad bytes (first %0d), want 0", bad, first); end
        read_obj(9'h1FF, d);
        checks++;
        if (d !== 8'hA5) begin errors++; $display("FAIL basic_last_byte: got %h want a5", d); end
    endtask

    task automatic test_paced();
        int n = 0, t0 = -1, t1 = -1;
        cen_div = 4;
        repeat (4) @(negedge clk);
        mon_reset();
        pulse_trig();
        while (busy && n < 5000) begin
            mon_cycle(); n++;
            if (!busak_n && t0 < 0) t0 = n;
            if (t0 >= 0 && busrq_n && t1 < 0) t1 = n;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL paced_timeout: busy %b after %0d clk, want 0", busy, n); end
        checks++;
        if (t1 - t0 < 2047 || t1 - t0 > 2050) begin
            errors++; $display("FAIL paced_duration: got %0d clk grant-to-release, want 2047..2050", t1 - t0);
        end
        checks++;
        if (m_steps != LEN - 1) begin errors++; $display("FAIL paced_steps: got %0d want %0d", m_steps, LEN - 1); end
        checks++;
        if (m_bad != 0) begin errors++; $display("FAIL paced_step_rule: got %0d bad steps want 0", m_bad); end
        cen_div = 1;
    endtask

    task automatic test_pending();
        int n = 0;
        int t2 = $urandom_range(32, 256);
        int t3 = t2 + $urandom_range(5, 100);
        bit fired2 = 0, fired3 = 0;
        int exp_dmas = 1;
        mon_reset();
        pulse_trig();
        while (busy && n < 4000) begin
            mon_cycle(); n++;
            dma_cs = 1'b0; wr_n = 1'b1;
            if (!fired2 && m_low >= 2 && int'(dma_addr) == t2) begin
                dma_cs = 1'b1; wr_n = 1'b0; fired2 = 1;
            end else if (fired2 && !fired3 && m_low >= 2 && int'(dma_addr) == t3) begin
                dma_cs = 1'b1; wr_n = 1'b0; fired3 = 1;
            end
        end
        dma_cs = 1'b0; wr_n = 1'b1;
        if (fired2 || fired3) exp_dmas = 2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL pend_timeout: busy %b after %0d clk, want 0", busy, n); end
        repeat (20) mon_cycle();
        checks++;
        if (m_rq_falls != exp_dmas) begin errors++; $display("FAIL pend_requests: got %0d want %0d", m_rq_falls, exp_dmas); end
        checks++;
        if (m_steps != exp_dmas * (LEN - 1) || m_bad != 0) begin
            errors++; $display("FAIL pend_steps: got %0d steps %0d bad, want %0d steps 0 bad", m_steps, m_bad, exp_dmas * (LEN - 1));
        end
        checks++;
        if (busrq_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL pend_final: got busrq_n %b busy %b want 1 0", busrq_n, busy);
        end
    endtask

    task automatic test_abort();
        int n = 0, bad, first;
        fill_random();
        pulse_trig();
        while (!(busy && !busak_n && dma_addr == 9'h080) && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (dma_addr !== 9'h080) begin errors++; $display("FAIL abort_reach: got addr %h want 080", dma_addr); end
        force_rel = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++;
        if (busrq_n !== 1'b1) begin errors++; $display("FAIL abort_busrq_n: got %b want 1", busrq_n); end
        repeat (4) @(negedge clk);
        force_rel = 1'b0;
        for (int i = 0; i < 'h7F; i++) exp_buf[i] = vram[i];
        scan(bad, first);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_buffer: %0d bad bytes (first %0d), want 0", bad, first); end
    endtask

    task automatic test_reset_mid();
        int n = 0, bad, first;
        bit to;
        fill_random();
        pulse_trig();
        while (!(busy && !busak_n && dma_addr == 9'h100) && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (dma_addr !== 9'h100) begin errors++; $display("FAIL rstmid_reach: got addr %h want 100", dma_addr); end
        rst = 1'b1;
        #1;
        checks++;
        if (busrq_n !== 1'b1) begin errors++; $display("FAIL rstmid_busrq_n: got %b want 1", busrq_n); end
        checks++;
        if (busy !== 1'b0 || dma_addr !== '0) begin
            errors++; $display("FAIL rstmid_state: got busy %b addr %h want 0 000", busy, dma_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 'hFF; i++) exp_buf[i] = vram[i];
        scan(bad, first);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstmid_buffer: %0d bad bytes (first %0d), want 0", bad, first); end
        fill_random();
        pulse_trig();
        wait_idle(3000, to);
        checks++;
        if (to) begin errors++; $display("FAIL rstmid_rerun_timeout: busy %b want 0", busy); end
        for (int i = 0; i < LEN; i++) exp_buf[i] = vram[i];
        scan(bad, first);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstmid_rerun_buffer: %0d bad bytes (first %0d), want 0", bad, first); end
    endtask

`ifdef JTPANG_OBJDMA_DBUF_EN
    task automatic lvbl_fall();
        @(negedge clk); lvbl = 1'b0;
        repeat (3) @(negedge clk);
        lvbl = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_dbuf();
        int bad, first;
        bit to;
        fill_random();
        pulse_trig();
        wait_idle(3000, to);
        checks++;
        if (to) begin errors++; $display("FAIL dbuf_dma1_timeout: busy %b want 0", busy); end
        for (int i = 0; i < LEN; i++) exp_buf[i] = vram[i];
        lvbl_fall();
        scan(bad, first);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL dbuf_swap1: %0d bad bytes (first %0d), want 0", bad, first); end
        fill_random();
        pulse_trig();
        wait_idle(3000, to);
        checks++;
        if (to) begin errors++; $display("FAIL dbuf_dma2_timeout: busy %b want 0", busy); end
        scan(bad, first);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL dbuf_before_swap: %0d bad bytes (first %0d), want 0", bad, first); end
        for (int i = 0; i < LEN; i++) exp_buf[i] = vram[i];
        lvbl_fall();
        scan(bad, first);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL dbuf_swap2: %0d bad bytes (first %0d), want 0", bad, first); end
        lvbl_fall();
        scan(bad, first);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL dbuf_no_swap: %0d bad bytes (first %0d), want 0", bad, first); end
    endtask
`else
    task automatic test_lvbl_ignored();
        logic [7:0] d;
        int a = $urandom_range(0, LEN - 1);
        read_obj(a, d);
        checks++;
        if (d !== exp_buf[a]) begin errors++; $display("FAIL lvbl_before: got %h want %h", d, exp_buf[a]); end
        @(negedge clk); lvbl = 1'b0;
        repeat (3) @(negedge clk);
        lvbl = 1'b1;
        read_obj(a, d);
        checks++;
        if (d !== exp_buf[a]) begin errors++; $display("FAIL lvbl_after: got %h want %h", d, exp_buf[a]); end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) vram[i] = 8'h00;
        test_reset();
`ifdef JTPANG_OBJDMA_DBUF_EN
        test_dbuf();
`else
        test_basic();
        test_paced();
        test_pending();
        test_abort();
        test_reset_mid();
        test_lvbl_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
